// File: rtl/pipelined_addsub.sv
// Pipelined SIMD add/subtract unit.
// Each lane adds two WIDTH-bit addends whose carry chain is cut into STAGES
// segments, one segment per register stage. A capture stage registers the
// prepared addends when an operation is accepted, so an operation accepted at
// edge N is presented on the outputs after edge N+STAGES. Saturation and the
// per-lane flags are resolved just before the output registers. A single
// global advance enable moves the whole pipeline, bubbles included.
module pipelined_addsub #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 4,
  parameter int STAGES    = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic                   in_sat,
  input  logic [LANES-1:0]       in_cin,
  input  logic [LANES*WIDTH-1:0] in_src1,
  input  logic [LANES*WIDTH-1:0] in_src2,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic [LANES-1:0]       out_carry,
  output logic [LANES-1:0]       out_ovf,
  output logic [LANES-1:0]       out_zero,
  output logic [LANES-1:0]       out_neg,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic                   busy
);

  localparam int LW  = LANES * WIDTH;
  localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_RSUB = 2'b10;

  // Global advance: the whole pipeline moves unless a result is being held.
  logic adv;

  // Addends after operand selection/inversion, ready for the adder.
  logic [LW-1:0]    xa_in;
  logic [LW-1:0]    xb_in;
  logic [LANES-1:0] cy_in;

  // Per-stage state: bank k feeds carry segment k.
  logic [STAGES-1:0]                vld;
  logic [STAGES-1:0][LW-1:0]        xa_q;
  logic [STAGES-1:0][LW-1:0]        xb_q;
  logic [STAGES-1:0][LW-1:0]        sum_q;
  logic [STAGES-1:0][LANES-1:0]     cy_q;
  logic [STAGES-1:0]                sat_q;
  logic [STAGES-1:0][TAG_WIDTH-1:0] tag_q;

  // Partial sums and carries after each stage has added its segment.
  logic [STAGES-1:0][LW-1:0]    sum_nxt;
  logic [STAGES-1:0][LANES-1:0] cy_nxt;

  // Final-stage resolution feeding the output registers.
  logic [LW-1:0]    res_fin;
  logic [LANES-1:0] ovf_fin;
  logic [LANES-1:0] zero_fin;
  logic [LANES-1:0] neg_fin;
  logic [WIDTH-1:0] raw_lane;
  logic [WIDTH-1:0] res_lane;
  logic             msb_a;
  logic             msb_b;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign busy     = (|vld) || out_valid;

  // Turn each operation into a plain addition: pick and invert the addends
  // and choose the carry-in (only ADD uses the external carry-in).
  always_comb begin
    xa_in = '0;
    xb_in = '0;
    cy_in = '0;
    for (int l = 0; l < LANES; l++) begin
      case (in_op)
        OP_ADD: begin
          xa_in[l*WIDTH +: WIDTH] = in_src1[l*WIDTH +: WIDTH];
          xb_in[l*WIDTH +: WIDTH] = in_src2[l*WIDTH +: WIDTH];
          cy_in[l]                = in_cin[l];
        end
        OP_SUB: begin
          xa_in[l*WIDTH +: WIDTH] = in_src1[l*WIDTH +: WIDTH];
          xb_in[l*WIDTH +: WIDTH] = ~in_src2[l*WIDTH +: WIDTH];
          cy_in[l]                = 1'b1;
        end
        OP_RSUB: begin
          xa_in[l*WIDTH +: WIDTH] = in_src2[l*WIDTH +: WIDTH];
          xb_in[l*WIDTH +: WIDTH] = ~in_src1[l*WIDTH +: WIDTH];
          cy_in[l]                = 1'b1;
        end
        default: begin
          xa_in[l*WIDTH +: WIDTH] = '0;
          xb_in[l*WIDTH +: WIDTH] = ~in_src2[l*WIDTH +: WIDTH];
          cy_in[l]                = 1'b1;
        end
      endcase
    end
  end

  // One carry segment per stage; the last segment takes whatever bits remain,
  // and a segment with no bits simply passes the carry through.
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    localparam int LO  = k * SEG;
    localparam int HI  = (LO + SEG > WIDTH) ? WIDTH : LO + SEG;
    localparam int LEN = (HI > LO) ? HI - LO : 0;

    if (LEN > 0) begin : g_add
      logic [LW-1:0]    seg_sum;
      logic [LANES-1:0] seg_cy;

      // Add this segment in every lane using the carry held from the previous stage.
      always_comb begin
        seg_sum = sum_q[k];
        seg_cy  = cy_q[k];
        for (int l = 0; l < LANES; l++) begin
          {seg_cy[l], seg_sum[l*WIDTH+LO +: LEN]} =
            {1'b0, xa_q[k][l*WIDTH+LO +: LEN]} +
            {1'b0, xb_q[k][l*WIDTH+LO +: LEN]} +
            {{LEN{1'b0}}, cy_q[k][l]};
        end
      end

      assign sum_nxt[k] = seg_sum;
      assign cy_nxt[k]  = seg_cy;
    end else begin : g_pass
      assign sum_nxt[k] = sum_q[k];
      assign cy_nxt[k]  = cy_q[k];
    end
  end

  // Resolve overflow, saturation and the result flags for each lane.
  always_comb begin
    res_fin  = '0;
    ovf_fin  = '0;
    zero_fin = '0;
    neg_fin  = '0;
    raw_lane = '0;
    res_lane = '0;
    msb_a    = 1'b0;
    msb_b    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      raw_lane   = sum_nxt[STAGES-1][l*WIDTH +: WIDTH];
      msb_a      = xa_q[STAGES-1][l*WIDTH + WIDTH - 1];
      msb_b      = xb_q[STAGES-1][l*WIDTH + WIDTH - 1];
      ovf_fin[l] = (msb_a == msb_b) && (raw_lane[WIDTH-1] != msb_a);
      if (sat_q[STAGES-1] && ovf_fin[l]) begin
        res_lane = msb_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        res_lane = raw_lane;
      end
      res_fin[l*WIDTH +: WIDTH] = res_lane;
      zero_fin[l]               = (res_lane == '0);
      neg_fin[l]                = res_lane[WIDTH-1];
    end
  end

  // Valid chain and output registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= '0;
      out_ovf    <= '0;
      out_zero   <= '0;
      out_neg    <= '0;
      out_tag    <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int j = 1; j < STAGES; j++) begin
        vld[j] <= vld[j-1];
      end
      out_valid <= vld[STAGES-1];
      if (vld[STAGES-1]) begin
        out_result <= res_fin;
        out_carry  <= cy_nxt[STAGES-1];
        out_ovf    <= ovf_fin;
        out_zero   <= zero_fin;
        out_neg    <= neg_fin;
        out_tag    <= tag_q[STAGES-1];
      end
    end
  end

  // Operand and partial-sum banks; contents only matter where vld is set.
  always_ff @(posedge clk) begin
    if (adv) begin
      xa_q[0]  <= xa_in;
      xb_q[0]  <= xb_in;
      cy_q[0]  <= cy_in;
      sum_q[0] <= '0;
      sat_q[0] <= in_sat;
      tag_q[0] <= in_tag;
      for (int j = 1; j < STAGES; j++) begin
        xa_q[j]  <= xa_q[j-1];
        xb_q[j]  <= xb_q[j-1];
        cy_q[j]  <= cy_nxt[j-1];
        sum_q[j] <= sum_nxt[j-1];
        sat_q[j] <= sat_q[j-1];
        tag_q[j] <= tag_q[j-1];
      end
    end
  end

endmodule
